// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART tx line among NUM_REQ requesters.
// Each grant sends a header byte followed by req_len payload bytes, back to back, then
// returns to IDLE for at least one clock. All outputs are registered.
// Optional feature: define UART_TX_PARITY_EN to append an even-parity bit to every frame.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned LEN_W        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_header,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         data_ack,
    output logic [NUM_REQ-1:0]         done,
    output logic [2:0]                 grant_id,
    output logic                       busy,
    output logic                       tx
);

    localparam int unsigned        CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         LAST_ID  = 3'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         byte_q;
    logic [LEN_W-1:0]   rem_q;
    logic [2:0]         grant_q;
    logic [2:0]         rr_ptr_q;
    logic               busy_q;
    logic               tx_q;
    logic [NUM_REQ-1:0] data_ack_q;
    logic [NUM_REQ-1:0] done_q;

    logic               bit_end;
    logic               pick_found;
    logic [2:0]         pick_id;
    logic [3:0]         cand_sum;
    logic [2:0]         cand;
    logic [7:0]         pick_hdr;
    logic [LEN_W-1:0]   pick_len;
    logic [7:0]         cur_data;

    assign bit_end = (cnt_q == CNT_LAST);

    // Round-robin search: first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand_sum   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + 4'(k);
            if (cand_sum >= 4'(NUM_REQ)) begin
                cand_sum = cand_sum - 4'(NUM_REQ);
            end
            cand = cand_sum[2:0];
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!pick_found && cand == 3'(i) && req_valid[i]) begin
                    pick_found = 1'b1;
                    pick_id    = cand;
                end
            end
        end
    end

    // Per-requester field muxes: winner's header/length, current owner's payload byte.
    always_comb begin
        pick_hdr = '0;
        pick_len = '0;
        cur_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_id == 3'(i)) begin
                pick_hdr = req_header[8*i +: 8];
                pick_len = req_len[LEN_W*i +: LEN_W];
            end
            if (grant_q == 3'(i)) begin
                cur_data = req_data[8*i +: 8];
            end
        end
    end

    // Packet FSM with bit timer, serializer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_q     <= '0;
            rem_q      <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
            data_ack_q <= '0;
            done_q     <= '0;
        end else begin
            data_ack_q <= '0;
            done_q     <= '0;
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (pick_found) begin
                        grant_q <= pick_id;
                        busy_q  <= 1'b1;
                        byte_q  <= pick_hdr;
                        rem_q   <= pick_len;
                        cnt_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= byte_q[0];
                        state_q   <= StData;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= ^byte_q;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= byte_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (rem_q != '0) begin
                            // Latch next payload byte and start its frame with no gap.
                            byte_q     <= cur_data;
                            rem_q      <= rem_q - LEN_W'(1);
                            data_ack_q <= ONE << grant_q;
                            tx_q       <= 1'b0;
                            state_q    <= StStart;
                        end else begin
                            done_q   <= ONE << grant_q;
                            busy_q   <= 1'b0;
                            rr_ptr_q <= (grant_q == LAST_ID) ? 3'd0 : grant_q + 3'd1;
                            tx_q     <= 1'b1;
                            state_q  <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign data_ack = data_ack_q;
    assign done     = done_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes expected line bytes and done
// pulses into queues; independent monitors decode tx and watch done and compare.
module tb_uart_tx_scheduler;

    localparam int NR  = 4;
    localparam int CPB = 4;
    localparam int LW  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR*8-1:0] req_header;
    logic [NR*LW-1:0] req_len;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0] data_ack;
    logic [NR-1:0] done;
    logic [2:0]    grant_id;
    logic          busy;
    logic          tx;

    uart_tx_scheduler #(
        .NUM_REQ      (NR),
        .CLKS_PER_BIT (CPB),
        .LEN_W        (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_header (req_header),
        .req_len    (req_len),
        .req_data   (req_data),
        .data_ack   (data_ack),
        .done       (done),
        .grant_id   (grant_id),
        .busy       (busy),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    bit          mon_en = 1'b1;
    logic [10:0] exp_q[$];      // {grant id, byte}
    int          exp_done[$];
    logic [7:0]  pl [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Line monitor: decode each frame at bit centres and compare with the scoreboard.
    initial begin
        logic [7:0]  b;
        logic [2:0]  gid;
        logic        stop_bit;
        logic        par;
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b1 && tx === 1'b0) begin
                gid = grant_id;
                par = 1'b0;
                repeat (CPB + CPB / 2) @(negedge clk);
                b[0] = tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                par = tx;
`endif
                repeat (CPB) @(negedge clk);
                stop_bit = tx;
                repeat (CPB - CPB / 2 - 1) @(negedge clk);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", b);
                end else begin
                    e = exp_q.pop_front();
                    check("line_byte", {24'd0, b}, {24'd0, e[7:0]});
                    check("frame_grant_id", {29'd0, gid}, {29'd0, e[10:8]});
                    check("stop_bit", {31'd0, stop_bit}, 32'd1);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", {31'd0, par}, {31'd0, ^e[7:0]});
`endif
                end
            end
        end
    end

    // Done monitor: every done pulse must match the next expected owner.
    initial begin
        int         id;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (done !== '0) begin
                if (exp_done.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_done: got 0x%0h, expected 0x0", done);
                end else begin
                    id = exp_done.pop_front();
                    oh = 4'b0001 << id;
                    check("done_onehot", {28'd0, done}, {28'd0, oh});
                end
            end
        end
    end

    // Issue one packet from requester id; optionally drop it after the first ack and raise
    // late_id instead. Returns ack count, first/last ack and done offsets from the start bit.
    task automatic run_pkt(input int id, input logic [7:0] hdr, input int len, input int late_id,
                           output int acks, output int first_ack, output int last_ack,
                           output int done_at);
        int n;
        exp_q.push_back({3'(id), hdr});
        for (int j = 0; j < len; j++) exp_q.push_back({3'(id), pl[j]});
        exp_done.push_back(id);
        req_header[8*id +: 8] = hdr;
        req_len[LW*id +: LW]  = 4'(len);
        req_data[8*id +: 8]   = pl[0];
        req_valid[id]         = 1'b1;
        @(negedge clk);
        check("start_latency_tx", {31'd0, tx}, 32'd0);
        check("grant_id", {29'd0, grant_id}, 32'(id));
        check("busy_on_grant", {31'd0, busy}, 32'd1);
        acks = 0; first_ack = -1; last_ack = -1; done_at = -1; n = 0;
        while (n < (len + 2) * FRAME) begin
            @(negedge clk);
            n++;
            if (data_ack[id]) begin
                acks++;
                if (acks == 1) first_ack = n;
                last_ack = n;
                if (acks < 16) req_data[8*id +: 8] = pl[acks];
                if (late_id >= 0 && acks == 1) begin
                    req_valid[id]      = 1'b0;
                    req_valid[late_id] = 1'b1;
                end
            end
            if (done[id]) begin
                done_at = n;
                break;
            end
        end
        req_valid[id] = 1'b0;
    endtask

    initial begin
        int acks, fa, la, dn, bad, k, last_done, p_start, p_done;
        bit prev_busy;
        rst = 1'b0;
        req_valid = '0; req_header = '0; req_len = '0; req_data = '0;
        for (int i = 0; i < 16; i++) pl[i] = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant_id", {29'd0, grant_id}, 32'd0);
        check("rst_data_ack", {28'd0, data_ack}, 32'd0);
        check("rst_done", {28'd0, done}, 32'd0);
        rst = 1'b1;

        // Idle for 100 cycles without requests.
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_100_cycles", 32'(bad), 32'd0);

        // All requesters held valid, len 0: grants 0,1,2,3,0 with one idle clk between.
        for (int i = 0; i < NR; i++) begin
            req_header[8*i +: 8] = 8'h10 + 8'(i);
            req_len[LW*i +: LW]  = '0;
        end
        for (int p = 0; p < 5; p++) begin
            exp_q.push_back({3'(p % NR), 8'h10 + 8'(p % NR)});
            exp_done.push_back(p % NR);
        end
        req_valid = 4'hF;
        prev_busy = 1'b0; last_done = 0; p_start = 0; p_done = 0; k = 0;
        while (k < 6 * (FRAME + 1)) begin
            @(negedge clk);
            k++;
            if (busy && !prev_busy) begin
                check("rr_grant_order", {29'd0, grant_id}, 32'(p_start % NR));
                if (p_start > 0) check("rr_idle_gap", 32'(k - last_done), 32'd1);
                p_start++;
            end
            if (done !== '0) begin
                last_done = k;
                p_done++;
                if (p_done == 5) begin
                    req_valid = '0;
                    break;
                end
            end
            prev_busy = busy;
        end
        check("rr_packets_started", 32'(p_start), 32'd5);

        // Requester 2, header 0xA5, len 0.
        run_pkt(2, 8'hA5, 0, -1, acks, fa, la, dn);
        check("hdr_only_acks", 32'(acks), 32'd0);
        check("hdr_only_done_cycle", 32'(dn), 32'(FRAME));
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("tx_idle_after_done", {31'd0, tx}, 32'd1);

        // Requester 0, header 0x3C, payload 0x01, 0xFF.
        pl[0] = 8'h01; pl[1] = 8'hFF;
        run_pkt(0, 8'h3C, 2, -1, acks, fa, la, dn);
        check("len2_acks", 32'(acks), 32'd2);
        check("len2_first_ack", 32'(fa), 32'(FRAME));
        check("len2_last_ack", 32'(la), 32'(2 * FRAME));
        check("len2_done_cycle", 32'(dn), 32'(3 * FRAME));

        // Owner 3 drops req_valid mid-payload; requester 1 arrives during busy.
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        req_header[15:8] = 8'h99;
        req_len[7:4]     = 4'd0;
        run_pkt(3, 8'h5A, 3, 1, acks, fa, la, dn);
        check("drop_acks", 32'(acks), 32'd3);
        check("drop_done_cycle", 32'(dn), 32'(4 * FRAME));
        exp_q.push_back({3'd1, 8'h99});
        exp_done.push_back(1);
        @(negedge clk);
        check("late_req_start", {31'd0, tx}, 32'd0);
        check("late_req_grant", {29'd0, grant_id}, 32'd1);
        dn = -1;
        for (int n = 1; n <= 2 * FRAME; n++) begin
            @(negedge clk);
            if (done[1]) begin
                dn = n;
                break;
            end
        end
        req_valid[1] = 1'b0;
        check("late_req_done_cycle", 32'(dn), 32'(FRAME));

        // Header 0x07: odd popcount, so the parity bit (when built) is 1.
        run_pkt(2, 8'h07, 0, -1, acks, fa, la, dn);
        check("hdr07_frame_len", 32'(dn), 32'(FRAME));

        // Scoreboard drained.
        repeat (4) @(negedge clk);
        check("bytes_drained", 32'(exp_q.size()), 32'd0);
        check("done_drained", 32'(exp_done.size()), 32'd0);

        // Reset mid-DATA aborts: tx high immediately, no done afterwards.
        mon_en = 1'b0;
        req_header[7:0] = 8'h00;
        req_len[3:0]    = 4'd5;
        req_valid[0]    = 1'b1;
        @(negedge clk);
        repeat (2 * CPB) @(negedge clk);
        check("pre_abort_tx_low", {31'd0, tx}, 32'd0);
        rst = 1'b0;
        #1;
        check("abort_tx_high", {31'd0, tx}, 32'd1);
        check("abort_busy_low", {31'd0, busy}, 32'd0);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (done !== '0 || tx !== 1'b1) bad++;
        end
        check("no_done_after_abort", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
